// File: rtl/fetch.sv
// Instruction fetch unit.
// Owns the program counter and fetches one 8-bit instruction at a time from
// program memory using a req/ack handshake. It passes each fetched instruction
// to the controller using a valid/ready handshake. The controller can redirect
// the PC with jmp/jmp_addr and can hold off new fetches with halt.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   mem_req, mem_addr      fetch request and address to program memory
//   mem_ack, mem_data      memory response, sampled when mem_req & mem_ack
//   instr, instr_pc        instruction byte and the address it was fetched from
//   instr_valid            instr/instr_pc hold a valid instruction
//   instr_ready            controller accepts instr this cycle
//   jmp, jmp_addr          redirect the next fetch to jmp_addr
//   halt                   level; blocks entry into a new fetch
module fetch #(
   parameter int unsigned        ADDR_W    = 8,
   parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic [7:0]        instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic              halt
);

   typedef enum logic [1:0] {StStop, StFetch, StValid} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              jmp_pend_q, jmp_pend_d;
   logic              mem_req_q, mem_req_d;
   logic              instr_valid_q, instr_valid_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      jmp_pend_d = jmp_pend_q;

      unique case (state_q)
         StStop: begin
            if (jmp) pc_d = jmp_addr;
            if (!halt) state_d = StFetch;
         end
         StFetch: begin
            if (mem_ack) begin
               if (jmp || jmp_pend_q) begin
                  // The returning data belongs to a path that has been redirected.
                  // Discard it and refetch from the latest target.
                  if (jmp) pc_d = jmp_addr;
                  jmp_pend_d = 1'b0;
                  state_d    = halt ? StStop : StFetch;
               end else begin
                  instr_d    = mem_data;
                  instr_pc_d = mem_addr_q;
                  pc_d       = pc_q + ADDR_W'(1);
                  state_d    = StValid;
               end
            end else if (jmp) begin
               // The request cannot be withdrawn. Remember the redirect instead.
               pc_d       = jmp_addr;
               jmp_pend_d = 1'b1;
            end
         end
         StValid: begin
            if (jmp) begin
               pc_d    = jmp_addr;
               state_d = halt ? StStop : StFetch;
            end else if (instr_ready) begin
               state_d = halt ? StStop : StFetch;
            end
         end
         default: state_d = StStop;
      endcase

      // Latch a new address only when a new request starts. The address of an
      // outstanding request stays fixed until it is acked.
      if (state_d == StFetch && !(state_q == StFetch && !mem_ack)) begin
         mem_addr_d = pc_d;
      end
   end

   assign mem_req_d     = (state_d == StFetch);
   assign instr_valid_d = (state_d == StValid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StStop;
         pc_q          <= RESET_VEC;
         mem_addr_q    <= RESET_VEC;
         instr_q       <= 8'h00;
         instr_pc_q    <= '0;
         jmp_pend_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_addr_q    <= mem_addr_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         jmp_pend_q    <= jmp_pend_d;
         mem_req_q     <= mem_req_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch unit.
// Stimulus is applied 2ns after each rising clock edge. Accepted instructions are
// checked at the falling edge against a queue of expected {instr_pc, instr} values.
module tb_fetch;

   logic       clk;
   logic       rst_n;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_data;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       jmp;
   logic [7:0] jmp_addr;
   logic       halt;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem [256];
   logic [15:0] exp_q [$];

   fetch #(
      .ADDR_W   (8),
      .RESET_VEC(8'h00)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .jmp        (jmp),
      .jmp_addr   (jmp_addr),
      .halt       (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: each completed handshake (not a flush) pops one expectation.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !jmp) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery",
                     instr_pc, instr);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== e) begin
               errors++;
               $display("FAIL sb_instr: got pc=%h instr=%h, required pc=%h instr=%h",
                        instr_pc, instr, e[15:8], e[7:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a memory response for the current request. Optionally queue it as expected.
   task automatic ack_now(input bit expect_it);
      mem_ack  = 1'b1;
      mem_data = mem[mem_addr];
      if (expect_it) exp_q.push_back({mem_addr, mem[mem_addr]});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({mem_req, mem_addr, instr, instr_pc, instr_valid} !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b addr=%h instr=%h pc=%h valid=%b, required 0/00/00/00/0",
                  mem_req, mem_addr, instr, instr_pc, instr_valid);
      end
      tick();
      rst_n = 1'b1;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_req: got %b, required 0", mem_req);
      end
   endtask

   task automatic test_basic();
      bit prev_ack = 1'b0;
      int valids   = 0;
      int exp_addr = 0;
      instr_ready = 1'b1;
      for (int i = 0; i < 12 && valids < 3; i++) begin
         tick();
         checks++;
         if (instr_valid !== prev_ack) begin
            errors++;
            $display("FAIL basic_valid_latency: cycle %0d got %b, required %b", i, instr_valid, prev_ack);
         end
         if (mem_req) begin
            checks++;
            if (mem_addr !== 8'(exp_addr)) begin
               errors++;
               $display("FAIL basic_addr: got %h, required %h", mem_addr, 8'(exp_addr));
            end
            exp_addr++;
            ack_now(1'b1);
            prev_ack = 1'b1;
         end else begin
            mem_ack  = 1'b0;
            prev_ack = 1'b0;
         end
         if (instr_valid) valids++;
      end
      checks++;
      if (valids != 3) begin
         errors++;
         $display("FAIL basic_count: got %0d deliveries, required 3", valids);
      end
   endtask

   task automatic test_ack_delay();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL delay_hold: cycle %0d got req=%b addr=%h valid=%b, required 1/03/0",
                     i, mem_req, mem_addr, instr_valid);
         end
         if (i == 3) ack_now(1'b1);
      end
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h03, 8'h43}) begin
         errors++;
         $display("FAIL delay_valid: got valid=%b pc=%h instr=%h, required 1/03/43",
                  instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_stall();
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({instr_valid, instr, instr_pc, mem_req} !== {1'b1, 8'h43, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%b instr=%h pc=%h req=%b, required 1/43/03/0",
                     i, instr_valid, instr, instr_pc, mem_req);
         end
         if (i == 4) instr_ready = 1'b1;
      end
   endtask

   task automatic test_jmp_fetch();
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h04}) begin
         errors++;
         $display("FAIL stall_resume: got req=%b addr=%h, required 1/04", mem_req, mem_addr);
      end
      ack_now(1'b1);
      tick();
      mem_ack = 1'b0;
      tick();
      jmp      = 1'b1;
      jmp_addr = 8'h40;
      tick();
      jmp = 1'b0;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h05}) begin
         errors++;
         $display("FAIL jmp_hold_addr: got req=%b addr=%h, required 1/05", mem_req, mem_addr);
      end
      ack_now(1'b0);  // stale data for address 5
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h40, 1'b0}) begin
         errors++;
         $display("FAIL jmp_target: got req=%b addr=%h valid=%b, required 1/40/0",
                  mem_req, mem_addr, instr_valid);
      end
      ack_now(1'b1);
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({instr_valid, instr_pc} !== {1'b1, 8'h40}) begin
         errors++;
         $display("FAIL jmp_deliver: got valid=%b pc=%h, required 1/40", instr_valid, instr_pc);
      end
   endtask

   task automatic test_flush();
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h41}) begin
         errors++;
         $display("FAIL flush_pre: got req=%b addr=%h, required 1/41", mem_req, mem_addr);
      end
      ack_now(1'b0);  // this one gets flushed
      tick();
      mem_ack  = 1'b0;
      jmp      = 1'b1;
      jmp_addr = 8'h80;
      tick();
      jmp = 1'b0;
      checks++;
      if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h80}) begin
         errors++;
         $display("FAIL flush_redirect: got valid=%b req=%b addr=%h, required 0/1/80",
                  instr_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      jmp      = 1'b1;
      jmp_addr = 8'h90;
      tick();
      jmp_addr = 8'hA0;
      checks++;
      if (mem_addr !== 8'h80) begin
         errors++;
         $display("FAIL b2b_hold: got addr=%h, required 80", mem_addr);
      end
      ack_now(1'b0);  // ack coincides with the second jmp
      tick();
      jmp     = 1'b0;
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'hA0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_last_wins: got req=%b addr=%h valid=%b, required 1/A0/0",
                  mem_req, mem_addr, instr_valid);
      end
   endtask

   task automatic test_halt_wrap();
      jmp      = 1'b1;
      jmp_addr = 8'hFF;
      ack_now(1'b0);
      tick();
      jmp = 1'b0;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin
         errors++;
         $display("FAIL wrap_ff: got req=%b addr=%h, required 1/FF", mem_req, mem_addr);
      end
      ack_now(1'b1);
      tick();
      mem_ack = 1'b0;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL wrap_00: got req=%b addr=%h, required 1/00", mem_req, mem_addr);
      end
      ack_now(1'b1);
      halt = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({instr_valid, instr_pc, mem_req} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL halt_deliver: got valid=%b pc=%h req=%b, required 1/00/0",
                  instr_valid, instr_pc, mem_req);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({mem_req, instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL halt_stop: cycle %0d got req=%b valid=%b, required 0/0",
                     i, mem_req, instr_valid);
         end
      end
      halt = 1'b0;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin
         errors++;
         $display("FAIL halt_resume: got req=%b addr=%h, required 1/01", mem_req, mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_addr, instr_valid, instr} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: got req=%b addr=%h valid=%b instr=%h, required 0/00/0/00",
                  mem_req, mem_addr, instr_valid, instr);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL reset_restart: got req=%b addr=%h, required 1/00", mem_req, mem_addr);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d undelivered, required 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 17 + 16);
      rst_n       = 1'b0;
      mem_ack     = 1'b0;
      mem_data    = 8'h00;
      instr_ready = 1'b0;
      jmp         = 1'b0;
      jmp_addr    = 8'h00;
      halt        = 1'b0;

      test_reset();
      test_basic();
      test_ack_delay();
      test_stall();
      test_jmp_fetch();
      test_flush();
      test_back_to_back();
      test_halt_wrap();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
